// File: rtl/usr_ctrl.sv
// Command sequencer for a universal shift register: load, shift right/left, rotate right.
// Registered outputs, one cycle after acceptance. Define USR_CTRL_ROTATE_EN to make op=11 rotate right.
module usr_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             Clk,
   input  logic             clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_sin,
   input  logic [WIDTH-1:0] usr_q,
   output logic [1:0]       usr_sel,
   output logic [WIDTH-1:0] usr_pin,
   output logic             usr_sr_in,
   output logic             usr_sl_in,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam int               MSB2    = (WIDTH > 1) ? WIDTH - 2 : 0;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               sin_q, sin_d;

   logic [1:0]         sel_q, sel_d;
   logic [WIDTH-1:0]   pin_q, pin_d;
   logic               sr_q, sr_d;
   logic               sl_q, sl_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               accept;
   logic [CNT_W-1:0]   cnt_sat;
   logic               rot_bit;

   assign accept  = cmd_valid && ready_q;
   assign cnt_sat = (cmd_cnt > WIDTH_C) ? WIDTH_C : cmd_cnt;
   // MSB the register will hold after this edge: unchanged at acceptance, Q[W-2] mid-rotate.
   assign rot_bit = (state_q == SHIFT) ? usr_q[MSB2] : usr_q[WIDTH-1];

   always_ff @(posedge Clk) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= 2'b00;
         data_q  <= '0;
         sin_q   <= 1'b0;
         sel_q   <= 2'b00;
         pin_q   <= '0;
         sr_q    <= 1'b0;
         sl_q    <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         data_q  <= data_d;
         sin_q   <= sin_d;
         sel_q   <= sel_d;
         pin_q   <= pin_d;
         sr_q    <= sr_d;
         sl_q    <= sl_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      data_d  = data_q;
      sin_d   = sin_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d   = cmd_op;
               data_d = cmd_data;
               sin_d  = cmd_sin;
               cnt_d  = cnt_sat;
               case (cmd_op)
                  2'b00: state_d = LOAD;
                  2'b11: begin
`ifdef USR_CTRL_ROTATE_EN
                     state_d = (cnt_sat != '0) ? SHIFT : DONE;
`else
                     state_d = DONE;
                     cnt_d   = '0;
`endif
                  end
                  default: state_d = (cnt_sat != '0) ? SHIFT : DONE;
               endcase
            end
         end
         LOAD:  state_d = DONE;
         SHIFT: begin
            if (cnt_q != '0) cnt_d = cnt_q - ONE_C;
            if (cnt_q <= ONE_C) state_d = DONE;
         end
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are a function of the next state so they register in step with it.
      sel_d = 2'b00;
      pin_d = '0;
      sr_d  = 1'b0;
      sl_d  = 1'b0;
      case (state_d)
         LOAD: begin
            sel_d = 2'b11;
            pin_d = data_d;
         end
         SHIFT: begin
            case (op_d)
               2'b10: begin
                  sel_d = 2'b10;
                  sl_d  = sin_d;
               end
               2'b11: begin
                  sel_d = 2'b01;
                  sr_d  = rot_bit;
               end
               default: begin
                  sel_d = 2'b01;
                  sr_d  = sin_d;
               end
            endcase
         end
         default: ;
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
   end

   assign cmd_ready = ready_q;
   assign usr_sel   = sel_q;
   assign usr_pin   = pin_q;
   assign usr_sr_in = sr_q;
   assign usr_sl_in = sl_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_usr_ctrl.sv
// Directed bench for usr_ctrl (WIDTH=4) with a behavioural universal shift register in the loop.
module tb_usr_ctrl;

   logic       Clk;
   logic       clr;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [2:0] cmd_cnt;
   logic [3:0] cmd_data;
   logic       cmd_sin;
   logic [3:0] usr_q;
   logic [1:0] usr_sel;
   logic [3:0] usr_pin;
   logic       usr_sr_in;
   logic       usr_sl_in;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   int n01, n10, n11, nsr, nsl, done_at, done_len, ready_at, timed_out;
   logic [3:0] pin_seen;

   usr_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
      .Clk(Clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_sin(cmd_sin),
      .usr_q(usr_q), .usr_sel(usr_sel), .usr_pin(usr_pin),
      .usr_sr_in(usr_sr_in), .usr_sl_in(usr_sl_in), .busy(busy), .done(done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Controlled shift register: right moves Q[i]<=Q[i-1], left moves Q[i]<=Q[i+1].
   always @(posedge Clk) begin
      case (usr_sel)
         2'b01: usr_q <= {usr_q[2:0], usr_sr_in};
         2'b10: usr_q <= {usr_sl_in, usr_q[3:1]};
         2'b11: usr_q <= usr_pin;
         default: usr_q <= usr_q;
      endcase
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt,
                          input logic [3:0] data, input logic sin);
      cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_sin = sin;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      n01 = 0; n10 = 0; n11 = 0; nsr = 0; nsl = 0;
      done_at = -1; done_len = 0; ready_at = -1; timed_out = 1;
      pin_seen = 4'h0;
      for (int k = 1; k <= 40; k++) begin
         if (usr_sel == 2'b01) n01++;
         if (usr_sel == 2'b10) n10++;
         if (usr_sel == 2'b11) begin n11++; pin_seen = usr_pin; end
         if (usr_sr_in) nsr++;
         if (usr_sl_in) nsl++;
         if (done) begin
            if (done_at < 0) done_at = k;
            done_len++;
         end
         if (cmd_ready) begin
            ready_at  = k;
            timed_out = 0;
            break;
         end
         step();
      end
      chk("cmd_timeout", timed_out, 0);
   endtask

   int acc_cnt, acc_at1, done_prev, done_before2, dn;

   initial begin
      clr = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = 3'd0;
      cmd_data = 4'h0; cmd_sin = 1'b0; usr_q = 4'h0;
      step(); step();
      clr = 1'b0;
      chk("rst_sel", usr_sel, 2'b00);
      chk("rst_pin", usr_pin, 4'h0);
      chk("rst_ser", {usr_sr_in, usr_sl_in}, 2'b00);
      chk("rst_busy_done", {busy, done}, 2'b00);
      chk("rst_ready", cmd_ready, 1'b1);

      // Parallel load
      run_cmd(2'b00, 3'd0, 4'b1011, 1'b0);
      chk("ld_sel11_cycles", n11, 1);
      chk("ld_pin", pin_seen, 4'b1011);
      chk("ld_done_at", done_at, 2);
      chk("ld_done_len", done_len, 1);
      chk("ld_ready_at", ready_at, 3);
      chk("ld_reg", usr_q, 4'b1011);

      // Shift right 3 with fill 1
      run_cmd(2'b01, 3'd3, 4'h0, 1'b1);
      chk("sr_cycles", n01, 3);
      chk("sr_srin_cycles", nsr, 3);
      chk("sr_slin_cycles", nsl, 0);
      chk("sr_done_at", done_at, 4);
      chk("sr_done_len", done_len, 1);
      chk("sr_reg", usr_q, 4'b1111);

      // Shift left with saturating count, fill 0
      run_cmd(2'b10, 3'd7, 4'h0, 1'b0);
      chk("sl_sat_cycles", n10, 4);
      chk("sl_sat_other_sel", n01 + n11, 0);
      chk("sl_sat_done_at", done_at, 5);
      chk("sl_sat_reg", usr_q, 4'b0000);

      // Shift left 2 with fill 1
      run_cmd(2'b10, 3'd2, 4'h0, 1'b1);
      chk("sl_cycles", n10, 2);
      chk("sl_slin_cycles", nsl, 2);
      chk("sl_srin_cycles", nsr, 0);
      chk("sl_reg", usr_q, 4'b1100);

      // Zero-count shift: straight to DONE
      run_cmd(2'b01, 3'd0, 4'h0, 1'b1);
      chk("z_shift_cycles", n01 + n10 + n11, 0);
      chk("z_done_at", done_at, 1);
      chk("z_done_len", done_len, 1);
      chk("z_reg", usr_q, 4'b1100);

      // op=11 from register 1000
      run_cmd(2'b00, 3'd0, 4'b1000, 1'b0);
      chk("rot_preload", usr_q, 4'b1000);
      run_cmd(2'b11, 3'd1, 4'h0, 1'b0);
`ifdef USR_CTRL_ROTATE_EN
      chk("rot_cycles", n01, 1);
      chk("rot_srin", nsr, 1);
      chk("rot_done_at", done_at, 2);
      chk("rot_reg", usr_q, 4'b0001);
`else
      chk("nop_sel_cycles", n01 + n10 + n11, 0);
      chk("nop_srin", nsr + nsl, 0);
      chk("nop_done_at", done_at, 1);
      chk("nop_reg", usr_q, 4'b1000);
`endif

      // Abort a cnt=4 shift with clr in its second cycle
      cmd_op = 2'b01; cmd_cnt = 3'd4; cmd_sin = 1'b1; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("abort_c1_sel", usr_sel, 2'b01);
      step();
      chk("abort_c2_sel", usr_sel, 2'b01);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("abort_sel", usr_sel, 2'b00);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_ready", cmd_ready, 1'b1);
      dn = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (done) dn++;
      end
      chk("abort_no_done", dn, 0);

      // cmd_valid held high: one acceptance per IDLE visit
      cmd_op = 2'b01; cmd_cnt = 3'd1; cmd_sin = 1'b0; cmd_valid = 1'b1;
      acc_cnt = 0; acc_at1 = -1; done_prev = 0; done_before2 = 0;
      for (int s = 0; s < 10; s++) begin
         if (cmd_ready && cmd_valid) begin
            if (acc_cnt == 1) begin
               acc_at1 = s;
               done_before2 = done_prev;
            end
            acc_cnt++;
         end
         done_prev = done;
         step();
      end
      cmd_valid = 1'b0;
      chk("b2b_accepts", acc_cnt, 4);
      chk("b2b_second_at", acc_at1, 3);
      chk("b2b_done_before", done_before2, 1);
      timed_out = 1;
      for (int k = 0; k < 20; k++) begin
         if (cmd_ready) begin timed_out = 0; break; end
         step();
      end
      chk("b2b_drain", timed_out, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
